// File: rtl/ex_stage_pkg.sv
// Shared encodings, decode types and the instruction decoder for the EX stage.
package ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_LUI,
        ALU_HI,
        ALU_LO
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu;
        logic    use_imm;
        logic    muldiv;
        logic    is_div;
        logic    hilo;
    } dec_t;

    // ALU_NONE with muldiv=0 means the instruction leaves a bubble and has no HI/LO effect.
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.alu     = ALU_NONE;
        d.use_imm = 1'b0;
        d.muldiv  = 1'b0;
        d.is_div  = 1'b0;
        d.hilo    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU:  d.alu = ALU_ADD;
                    FN_SUBU:  d.alu = ALU_SUB;
                    FN_AND:   d.alu = ALU_AND;
                    FN_OR:    d.alu = ALU_OR;
                    FN_SLT:   d.alu = ALU_SLT;
                    FN_MFHI:  begin d.alu = ALU_HI; d.hilo = 1'b1; end
                    FN_MFLO:  begin d.alu = ALU_LO; d.hilo = 1'b1; end
                    FN_MULTU: begin d.muldiv = 1'b1; d.hilo = 1'b1; end
                    FN_DIVU:  begin d.muldiv = 1'b1; d.is_div = 1'b1; d.hilo = 1'b1; end
                    default:  ;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: begin d.alu = ALU_ADD; d.use_imm = 1'b1; end
            OP_ORI:   begin d.alu = ALU_OR; d.use_imm = 1'b1; end
            OP_LUI:   d.alu = ALU_LUI;
            default:  ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative unsigned multiply/divide unit (1 bit per cycle) owning the HI/LO registers.
module ex_muldiv
    import ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    output logic            busy_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              div_q, div_d;
    logic [XLEN:0]     sum, rem;
    logic [XLEN-1:0]   diff;
    logic              ge, last;

    assign last = (state_q == MD_BUSY) && (cnt_q == CNT_W'(XLEN - 1));

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem  = acc_q[2*XLEN-1:XLEN-1];
        ge   = (rem >= {1'b0, opnd_q});
        diff = rem[XLEN-1:0] - opnd_q;
        if (div_q) begin
            acc_step = ge ? {diff, acc_q[XLEN-2:0], 1'b1}
                          : {rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: ;
            MD_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    hi_d    = acc_step[2*XLEN-1:XLEN];
                    lo_d    = acc_step[XLEN-1:0];
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        // start_i is only raised when idle or on the final iteration, so a new op may follow back-to-back.
        if (start_i) begin
            state_d = MD_BUSY;
            cnt_d   = '0;
            div_d   = is_div_i;
            opnd_d  = is_div_i ? rt_i : rs_i;
            acc_d   = {{XLEN{1'b0}}, (is_div_i ? rs_i : rt_i)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Busy drops during the final iteration; readers get the result being written this edge.
    assign busy_o = (state_q == MD_BUSY) && !last;
    assign hi_o   = hi_d;
    assign lo_o   = lo_d;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, EX/MEM output registers and the HI/LO hazard stall.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [5:0]      opcode_in,
    input  logic [5:0]      funct_in,
    input  logic [4:0]      rwd_in,
    input  logic [XLEN-1:0] val_rs_in,
    input  logic [XLEN-1:0] val_rt_in,
    input  logic [XLEN-1:0] imm_in,
    output logic            stall_out,
    output logic [4:0]      rwd_out,
    output logic [5:0]      opcode_out,
    output logic [XLEN-1:0] alu_res_out,
    output logic [XLEN-1:0] val_rt_out
);

    dec_t            dec;
    logic            accept, md_start, md_busy;
    logic [XLEN-1:0] md_hi, md_lo, opb, res;
    logic [4:0]      rwd_q, rwd_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [XLEN-1:0] res_q, res_d, rt_q, rt_d;

    assign dec       = decode(opcode_in, funct_in);
    assign stall_out = valid_in & md_busy & dec.hilo;
    assign accept    = valid_in & ~stall_out;
    assign md_start  = accept & dec.muldiv;
    assign opb       = dec.use_imm ? imm_in : val_rt_in;

    ex_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (md_start),
        .is_div_i (dec.is_div),
        .rs_i     (val_rs_in),
        .rt_i     (val_rt_in),
        .busy_o   (md_busy),
        .hi_o     (md_hi),
        .lo_o     (md_lo)
    );

    always_comb begin
        res = '0;
        case (dec.alu)
            ALU_ADD: res = val_rs_in + opb;
            ALU_SUB: res = val_rs_in - opb;
            ALU_AND: res = val_rs_in & opb;
            ALU_OR:  res = val_rs_in | opb;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, ($signed(val_rs_in) < $signed(opb))};
            ALU_LUI: res = {imm_in[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            ALU_HI:  res = md_hi;
            ALU_LO:  res = md_lo;
            default: res = '0;
        endcase
    end

    always_comb begin
        opcode_d = '0;
        rwd_d    = '0;
        res_d    = '0;
        rt_d     = '0;
        if (accept && (dec.alu != ALU_NONE)) begin
            opcode_d = opcode_in;
            rwd_d    = rwd_in;
            res_d    = res;
            rt_d     = val_rt_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            rwd_q    <= '0;
            res_q    <= '0;
            rt_q     <= '0;
        end else begin
            opcode_q <= opcode_d;
            rwd_q    <= rwd_d;
            res_q    <= res_d;
            rt_q     <= rt_d;
        end
    end

    assign opcode_out  = opcode_q;
    assign rwd_out     = rwd_q;
    assign alu_res_out = res_q;
    assign val_rt_out  = rt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, random run against a reference model, corner sequences.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [5:0]  opcode_in = '0;
    logic [5:0]  funct_in = '0;
    logic [4:0]  rwd_in = '0;
    logic [31:0] val_rs_in = '0;
    logic [31:0] val_rt_in = '0;
    logic [31:0] imm_in = '0;
    logic        stall_out;
    logic [4:0]  rwd_out;
    logic [5:0]  opcode_out;
    logic [31:0] alu_res_out;
    logic [31:0] val_rt_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage #(
        .XLEN(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .opcode_in   (opcode_in),
        .funct_in    (funct_in),
        .rwd_in      (rwd_in),
        .val_rs_in   (val_rs_in),
        .val_rt_in   (val_rt_in),
        .imm_in      (imm_in),
        .stall_out   (stall_out),
        .rwd_out     (rwd_out),
        .opcode_out  (opcode_out),
        .alu_res_out (alu_res_out),
        .val_rt_out  (val_rt_out)
    );

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rwd;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [5:0]  e_op;
        logic [4:0]  e_rwd;
        logic [31:0] e_res;
        logic [31:0] e_rt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rwd,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
        valid_in  = v;
        opcode_in = op;
        funct_in  = fn;
        rwd_in    = rwd;
        val_rs_in = rs;
        val_rt_in = rt;
        imm_in    = imm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [5:0] op, input logic [4:0] rwd,
                            input logic [31:0] res, input logic [31:0] rt);
        chk({tag, ".opcode"}, 32'(opcode_out), 32'(op));
        chk({tag, ".rwd"}, 32'(rwd_out), 32'(rwd));
        chk({tag, ".res"}, alu_res_out, res);
        chk({tag, ".rt"}, val_rt_out, rt);
    endtask

    // Hold an HI/LO reader until stall drops; returns the number of stalled cycles observed.
    task automatic wait_stall(output int n);
        n = 0;
        while (stall_out === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic bit model_simple(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                                        input logic [31:0] hi, input logic [31:0] lo, output logic [31:0] r);
        bit ok = 1'b1;
        r = '0;
        if (op == OP_RTYPE) begin
            if (fn == FN_ADDU)      r = rs + rt;
            else if (fn == FN_SUBU) r = rs - rt;
            else if (fn == FN_AND)  r = rs & rt;
            else if (fn == FN_OR)   r = rs | rt;
            else if (fn == FN_SLT)  r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
            else if (fn == FN_MFHI) r = hi;
            else if (fn == FN_MFLO) r = lo;
            else ok = 1'b0;
        end else if (op == OP_ADDIU || op == OP_LW || op == OP_SW) r = rs + imm;
        else if (op == OP_ORI) r = rs | imm;
        else if (op == OP_LUI) r = imm << 16;
        else ok = 1'b0;
        return ok;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        logic [11:0] ops[16];
        int n;
        logic [31:0] m_hi, m_lo, p_hi, p_lo, cur_hi, cur_lo, r;
        logic [63:0] prod;
        int m_left;
        bit hold, ok, hz, acc, exp_stall;
        logic v;
        logic [5:0] op, fn;
        logic [4:0] rwd;
        logic [31:0] rs, rt, imm;

        tbl[0]  = '{1, OP_RTYPE, FN_ADDU, 5,  32'h7FFF_FFFF, 32'h1,         32'h0,         OP_RTYPE, 5,  32'h8000_0000, 32'h1};
        tbl[1]  = '{1, OP_RTYPE, FN_SUBU, 3,  32'h0,         32'h1,         32'h0,         OP_RTYPE, 3,  32'hFFFF_FFFF, 32'h1};
        tbl[2]  = '{1, OP_RTYPE, FN_AND,  6,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h0,         OP_RTYPE, 6,  32'h00F0_1200, 32'h0FF0_FF00};
        tbl[3]  = '{1, OP_RTYPE, FN_OR,   7,  32'h1200_0000, 32'h34,        32'h0,         OP_RTYPE, 7,  32'h1200_0034, 32'h34};
        tbl[4]  = '{1, OP_RTYPE, FN_SLT,  9,  32'hFFFF_FFFF, 32'h0,         32'h0,         OP_RTYPE, 9,  32'h1,         32'h0};
        tbl[5]  = '{1, OP_RTYPE, FN_SLT,  9,  32'h0,         32'hFFFF_FFFF, 32'h0,         OP_RTYPE, 9,  32'h0,         32'hFFFF_FFFF};
        tbl[6]  = '{1, OP_RTYPE, FN_SLT,  10, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         OP_RTYPE, 10, 32'h1,         32'h7FFF_FFFF};
        tbl[7]  = '{1, OP_ADDIU, 6'h00,   11, 32'hFFFF_FFFF, 32'h0,         32'h2,         OP_ADDIU, 11, 32'h1,         32'h0};
        tbl[8]  = '{1, OP_ORI,   6'h00,   12, 32'h1234_0000, 32'h0,         32'h5678,      OP_ORI,   12, 32'h1234_5678, 32'h0};
        tbl[9]  = '{1, OP_LW,    6'h00,   13, 32'h1000,      32'h0,         32'h10,        OP_LW,    13, 32'h1010,      32'h0};
        tbl[10] = '{1, OP_SW,    6'h00,   0,  32'h100,       32'hAB,        32'hFFFF_FFFC, OP_SW,    0,  32'hFC,        32'hAB};
        tbl[11] = '{1, OP_LUI,   6'h00,   14, 32'h0,         32'h0,         32'hABCD,      OP_LUI,   14, 32'hABCD_0000, 32'h0};
        tbl[12] = '{1, OP_RTYPE, FN_MFHI, 4,  32'h0,         32'h0,         32'h0,         OP_RTYPE, 4,  32'h0,         32'h0};
        tbl[13] = '{1, OP_RTYPE, 6'h3F,   8,  32'h55,        32'h66,        32'h0,         6'h00,    0,  32'h0,         32'h0};
        tbl[14] = '{1, 6'h3E,    6'h00,   8,  32'h55,        32'h66,        32'h77,        6'h00,    0,  32'h0,         32'h0};
        tbl[15] = '{0, OP_RTYPE, FN_ADDU, 8,  32'h55,        32'h66,        32'h0,         6'h00,    0,  32'h0,         32'h0};

        ops = '{{OP_RTYPE, FN_ADDU}, {OP_RTYPE, FN_SUBU}, {OP_RTYPE, FN_AND}, {OP_RTYPE, FN_OR},
                {OP_RTYPE, FN_SLT}, {OP_RTYPE, FN_MFHI}, {OP_RTYPE, FN_MFLO}, {OP_RTYPE, FN_MULTU},
                {OP_RTYPE, FN_MULTU}, {OP_RTYPE, FN_DIVU}, {OP_RTYPE, FN_DIVU}, {OP_ADDIU, 6'h00},
                {OP_ORI, 6'h00}, {OP_SW, 6'h00}, {OP_LUI, 6'h00}, {OP_RTYPE, 6'h3F}};

        // Reset state
        drive(1, OP_RTYPE, FN_ADDU, 5, 32'h1, 32'h2, 32'h0);
        tick();
        tick();
        chk_outs("reset", 6'h00, 5'd0, 32'h0, 32'h0);
        chk("reset.stall", 32'(stall_out), 32'h0);
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Single-cycle vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].rwd, tbl[i].rs, tbl[i].rt, tbl[i].imm);
            #1;
            chk($sformatf("tbl%0d.stall", i), 32'(stall_out), 32'h0);
            tick();
            chk_outs($sformatf("tbl%0d", i), tbl[i].e_op, tbl[i].e_rwd, tbl[i].e_res, tbl[i].e_rt);
        end

        // Randomized run against the reference model
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0; hold = 1'b0;
        v = 0; op = '0; fn = '0; rwd = '0; rs = '0; rt = '0; imm = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                v   = ($urandom_range(0, 4) != 0);
                {op, fn} = ops[$urandom_range(0, 15)];
                rwd = 5'($urandom);
                rs  = $urandom;
                rt  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
                imm = $urandom;
            end else begin
                rs = $urandom;
            end
            drive(v, op, fn, rwd, rs, rt, imm);
            cur_hi = (m_left == 1) ? p_hi : m_hi;
            cur_lo = (m_left == 1) ? p_lo : m_lo;
            hz = (op == OP_RTYPE) && (fn == FN_MFHI || fn == FN_MFLO || fn == FN_MULTU || fn == FN_DIVU);
            exp_stall = v && hz && (m_left > 1);
            acc = v && !exp_stall;
            ok = model_simple(op, fn, rs, rt, imm, cur_hi, cur_lo, r);
            #1;
            chk($sformatf("rnd%0d.stall", cyc), 32'(stall_out), 32'(exp_stall));
            tick();
            if (acc && ok) chk_outs($sformatf("rnd%0d", cyc), op, rwd, r, rt);
            else           chk_outs($sformatf("rnd%0d", cyc), 6'h00, 5'd0, 32'h0, 32'h0);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end
            if (acc && op == OP_RTYPE && fn == FN_MULTU) begin
                prod = 64'(rs) * 64'(rt);
                {p_hi, p_lo} = prod;
                m_left = 32;
            end else if (acc && op == OP_RTYPE && fn == FN_DIVU) begin
                p_lo = (rt == 0) ? 32'hFFFF_FFFF : rs / rt;
                p_hi = (rt == 0) ? rs : rs % rt;
                m_left = 32;
            end
            hold = exp_stall;
        end
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        repeat (40) tick();

        // MULTU max*max, MFHI right behind it
        drive(1, OP_RTYPE, FN_MULTU, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        tick();
        chk_outs("mul.issue", 6'h00, 5'd0, 32'h0, 32'h0);
        drive(1, OP_RTYPE, FN_MFHI, 7, 32'h0, 32'h0, 32'h0);
        #1;
        wait_stall(n);
        chk("mul.stall_cycles", 32'(n), 32'd31);
        tick();
        chk_outs("mul.mfhi", OP_RTYPE, 5'd7, 32'hFFFF_FFFE, 32'h0);
        drive(1, OP_RTYPE, FN_MFLO, 8, 32'h0, 32'h0, 32'h0);
        tick();
        chk_outs("mul.mflo", OP_RTYPE, 5'd8, 32'h0000_0001, 32'h0);

        // DIVU 100/7 with independent ADDUs (new operand values) while busy
        drive(1, OP_RTYPE, FN_DIVU, 0, 32'd100, 32'd7, 32'h0);
        tick();
        drive(1, OP_RTYPE, FN_ADDU, 2, 32'd3, 32'd4, 32'h0);
        #1;
        chk("div.addu1.stall", 32'(stall_out), 32'h0);
        tick();
        chk_outs("div.addu1", OP_RTYPE, 5'd2, 32'd7, 32'd4);
        drive(1, OP_RTYPE, FN_ADDU, 3, 32'd10, 32'd20, 32'h0);
        #1;
        chk("div.addu2.stall", 32'(stall_out), 32'h0);
        tick();
        chk_outs("div.addu2", OP_RTYPE, 5'd3, 32'd30, 32'd20);
        drive(1, OP_RTYPE, FN_MFLO, 4, 32'h0, 32'h0, 32'h0);
        #1;
        wait_stall(n);
        chk("div.stall_bounded", 32'(n < 100), 32'h1);
        tick();
        chk_outs("div.mflo", OP_RTYPE, 5'd4, 32'd14, 32'h0);
        drive(1, OP_RTYPE, FN_MFHI, 5, 32'h0, 32'h0, 32'h0);
        tick();
        chk_outs("div.mfhi", OP_RTYPE, 5'd5, 32'd2, 32'h0);

        // Divide by zero
        drive(1, OP_RTYPE, FN_DIVU, 0, 32'd5, 32'd0, 32'h0);
        tick();
        drive(1, OP_RTYPE, FN_MFLO, 6, 32'h0, 32'h0, 32'h0);
        #1;
        wait_stall(n);
        chk("div0.stall_cycles", 32'(n), 32'd31);
        tick();
        chk_outs("div0.mflo", OP_RTYPE, 5'd6, 32'hFFFF_FFFF, 32'h0);
        drive(1, OP_RTYPE, FN_MFHI, 6, 32'h0, 32'h0, 32'h0);
        tick();
        chk_outs("div0.mfhi", OP_RTYPE, 5'd6, 32'd5, 32'h0);

        // Reset 10 cycles into a MULTU aborts it
        drive(1, OP_RTYPE, FN_MULTU, 0, 32'd7, 32'd9, 32'h0);
        tick();
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        repeat (9) tick();
        drive(1, OP_RTYPE, FN_ADDU, 9, 32'd1, 32'd1, 32'h0);
        tick();
        chk_outs("rst.pre", OP_RTYPE, 5'd9, 32'd2, 32'd1);
        drive(1, OP_RTYPE, FN_MFHI, 9, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk_outs("rst.async", 6'h00, 5'd0, 32'h0, 32'h0);
        chk("rst.idle_stall", 32'(stall_out), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_outs("rst.mfhi", OP_RTYPE, 5'd9, 32'h0, 32'h0);
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        repeat (40) tick();
        drive(1, OP_RTYPE, FN_MFHI, 10, 32'h0, 32'h0, 32'h0);
        tick();
        chk_outs("rst.late_hi", OP_RTYPE, 5'd10, 32'h0, 32'h0);
        drive(1, OP_RTYPE, FN_MFLO, 11, 32'h0, 32'h0, 32'h0);
        tick();
        chk_outs("rst.late_lo", OP_RTYPE, 5'd11, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
